// File: rtl/decode_regfile_stage.sv
// Decode stage: field split, register file read, immediate/jump target, ID/EX register.
// Optional same-edge write-back bypass into captured operands: DECODE_WB_BYPASS_EN.
module decode_regfile_stage #(
    parameter int XLEN = 32,
    parameter int NUM_REGS = 32,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc4,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_load_pending,
    input  logic [AW-1:0]   ex_load_rt,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_opcode,
    output logic [5:0]      out_funct,
    output logic [AW-1:0]   out_rt,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] out_rs_data,
    output logic [XLEN-1:0] out_rt_data,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_jump_target
);

    logic [XLEN-1:0] regs [NUM_REGS];

    logic [AW-1:0]   rs;
    logic [AW-1:0]   rt;
    logic [AW-1:0]   rd;
    logic [5:0]      opcode;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm_val;
    logic [XLEN-1:0] target_val;
    logic            zero_ext;
    logic            stall;
    logic            capture;
    logic            unused_pc;

    assign rs     = in_instr[21 +: AW];
    assign rt     = in_instr[16 +: AW];
    assign rd     = in_instr[11 +: AW];
    assign opcode = in_instr[31:26];

    // Only the segment bits of PC+4 reach the jump target.
    assign unused_pc = ^in_pc4[27:0];

    always_comb begin
        rs_val = (rs == '0) ? '0 : regs[rs];
        rt_val = (rt == '0) ? '0 : regs[rt];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr == rs && rs != '0) rs_val = wb_data;
        if (wb_en && wb_addr == rt && rt != '0) rt_val = wb_data;
`endif
    end

    // andi/ori/xori take a zero-extended immediate.
    assign zero_ext = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);

    always_comb begin
        if (zero_ext)
            imm_val = {{(XLEN-16){1'b0}}, in_instr[15:0]};
        else
            imm_val = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
    end

    assign target_val = {in_pc4[XLEN-1:28], in_instr[25:0], 2'b00};

    assign stall = in_valid && ex_load_pending && (ex_load_rt != '0)
                && ((rs == ex_load_rt) || (rt == ex_load_rt));

    assign in_ready = (!out_valid || out_ready) && !stall && !flush;
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_opcode      <= '0;
            out_funct       <= '0;
            out_rt          <= '0;
            out_rd          <= '0;
            out_rs_data     <= '0;
            out_rt_data     <= '0;
            out_imm         <= '0;
            out_jump_target <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid       <= 1'b1;
            out_opcode      <= opcode;
            out_funct       <= in_instr[5:0];
            out_rt          <= rt;
            out_rd          <= rd;
            out_rs_data     <= rs_val;
            out_rt_data     <= rt_val;
            out_imm         <= imm_val;
            out_jump_target <= target_val;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Self-checking bench for decode_regfile_stage: directed steps then random traffic
// compared against a behavioural model of the register file and ID/EX entry.
module tb_decode_regfile_stage;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_load_pending;
    logic [4:0]  ex_load_rt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [31:0] out_rs_data;
    logic [31:0] out_rt_data;
    logic [31:0] out_imm;
    logic [31:0] out_jump_target;

    decode_regfile_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .in_pc4          (in_pc4),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .ex_load_pending (ex_load_pending),
        .ex_load_rt      (ex_load_rt),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_opcode      (out_opcode),
        .out_funct       (out_funct),
        .out_rt          (out_rt),
        .out_rd          (out_rd),
        .out_rs_data     (out_rs_data),
        .out_rt_data     (out_rt_data),
        .out_imm         (out_imm),
        .out_jump_target (out_jump_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [31:0] mregs [32];
    bit          seen_reset = 0;
    logic        e_valid = 0;
    logic [31:0] e_opcode, e_funct, e_rt, e_rd, e_rs_data, e_rt_data, e_imm, e_tgt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] opnd(input int r);
        if (r == 0) return 32'd0;
        if (BYP && wb_en && int'(wb_addr) == r) return wb_data;
        return mregs[r];
    endfunction

    task automatic cyc();
        int          f_rs, f_rt, op, u16;
        logic        st, rdy;
        @(negedge clk);
        f_rs = int'(in_instr[25:21]);
        f_rt = int'(in_instr[20:16]);
        st = in_valid && ex_load_pending && ex_load_rt != 0
             && (f_rs == int'(ex_load_rt) || f_rt == int'(ex_load_rt));
        rdy = (!e_valid || out_ready) && !st && !flush;
        if (rst_n && seen_reset) chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            seen_reset = 1;
            e_valid = 0;
            e_opcode = 0; e_funct = 0; e_rt = 0; e_rd = 0;
            e_rs_data = 0; e_rt_data = 0; e_imm = 0; e_tgt = 0;
        end else begin
            if (flush) begin
                e_valid = 0;
            end else if (in_valid && rdy) begin
                op = int'(in_instr[31:26]);
                u16 = int'(in_instr[15:0]);
                e_valid = 1;
                e_opcode = op;
                e_funct = in_instr % 64;
                e_rt = f_rt;
                e_rd = (in_instr >> 11) % 32;
                e_rs_data = opnd(f_rs);
                e_rt_data = opnd(f_rt);
                if (op >= 12 && op <= 14) e_imm = u16;
                else e_imm = (u16 >= 32768) ? u16 - 65536 : u16;
                e_tgt = (in_pc4 & 32'hF000_0000) + (in_instr % (1 << 26)) * 4;
            end else if (out_ready) begin
                e_valid = 0;
            end
            if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
        end
        #1;
        if (seen_reset) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
            if (e_valid || !rst_n) begin
                chk("opcode", {26'd0, out_opcode}, e_opcode);
                chk("funct", {26'd0, out_funct}, e_funct);
                chk("rt", {27'd0, out_rt}, e_rt);
                chk("rd", {27'd0, out_rd}, e_rd);
                chk("rs_data", out_rs_data, e_rs_data);
                chk("rt_data", out_rt_data, e_rt_data);
                chk("imm", out_imm, e_imm);
                chk("jump_target", out_jump_target, e_tgt);
            end
        end
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_instr = 0; in_pc4 = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        ex_load_pending = 0; ex_load_rt = 0; flush = 0; out_ready = 1;
        cyc(); cyc();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rs_data", out_rs_data, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        rst_n = 1;
        cyc();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // write r5, then read it
        wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
        cyc();
        wb_en = 0;
        in_valid = 1; in_instr = 32'h00A0_1820; in_pc4 = 32'h0000_0104;
        cyc();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_rs", out_rs_data, 32'h1234);
        chk("add_rt", out_rt_data, 32'd0);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_funct", {26'd0, out_funct}, 32'h20);

        in_instr = 32'h2001_FFFC;
        cyc();
        chk("addi_imm", out_imm, 32'hFFFF_FFFC);
        in_instr = 32'h3401_FFFC;
        cyc();
        chk("ori_imm", out_imm, 32'h0000_FFFC);

        // same-edge write-back and capture of r7
        in_instr = 32'h00E0_0820;
        wb_en = 1; wb_addr = 7; wb_data = 32'hAA;
        cyc();
        wb_en = 0;
        chk("bypass_rs", out_rs_data, BYP ? 32'hAA : 32'd0);

        // load-use stall on rt=4
        in_instr = 32'h0004_1020;
        ex_load_pending = 1; ex_load_rt = 4;
        #1;
        chk("stall_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        chk("stall_nocap", {31'd0, out_valid}, 32'd0);
        ex_load_pending = 0;
        cyc();
        chk("stall_cap", {31'd0, out_valid}, 32'd1);
        chk("stall_rd", {27'd0, out_rd}, 32'd2);

        // hold with back-pressure while r4 is rewritten
        out_ready = 0;
        in_instr = 32'h00A0_1820;
        wb_en = 1; wb_addr = 4; wb_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_rd", {27'd0, out_rd}, 32'd2);
            chk("hold_rt_data", out_rt_data, 32'd0);
        end
        wb_en = 0;
        flush = 1;
        cyc();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 0;

        // r0 is hard-wired; jal target
        in_valid = 0; out_ready = 1;
        wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF;
        cyc();
        wb_en = 0;
        in_valid = 1; in_instr = 32'h0C00_0100; in_pc4 = 32'h4000_0010;
        cyc();
        chk("jal_target", out_jump_target, 32'h4000_0400);
        chk("r0_read", out_rs_data, 32'd0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = $urandom;
            if ($urandom_range(0, 3) == 0)
                in_instr[31:26] = 6'(12 + $urandom_range(0, 2));
            in_pc4 = $urandom;
            wb_en = $urandom_range(0, 1);
            wb_addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) wb_addr = in_instr[25:21];
            wb_data = $urandom;
            ex_load_pending = ($urandom_range(0, 3) == 0);
            ex_load_rt = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) ex_load_rt = in_instr[20:16];
            flush = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
